// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the card dealer and the later hand-score block.
package card_dealer_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam int SUITS     = 4;

    localparam logic [11:0] LFSR_SEED = 12'hACE;
    // Right-shift Galois mask for x^12 + x^11 + x^10 + x^4 + 1
    localparam logic [11:0] LFSR_TAPS = 12'hE08;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } state_e;

    function automatic logic [4:0] points_of(input logic [3:0] rank);
        logic [4:0] pts;
        if (rank > 4'd10) begin
            pts = 5'd10;
        end else begin
            pts = {1'b0, rank};
        end
        return pts;
    endfunction

endpackage

// File: rtl/card_dealer_index_reduce.sv
// Combinational seed -> deck index (0..51): zero-pad, XOR an optional mask, fold 6-bit chunks.
module card_index_reduce
    import card_dealer_pkg::*;
#(
    parameter int SEED_WIDTH = 12,
    parameter int PAD_WIDTH  = ((SEED_WIDTH + 5) / 6) * 6
) (
    input  logic [SEED_WIDTH-1:0] seed_i,
    input  logic [PAD_WIDTH-1:0]  mask_i,
    output logic [5:0]            idx_o
);

    localparam int CHUNKS = PAD_WIDTH / 6;

    logic [PAD_WIDTH-1:0] padded_s;
    logic [5:0]           fold_s;

    // Fold the padded seed into 6 bits and bring it into deck range with one subtract
    always_comb begin
        padded_s = PAD_WIDTH'(seed_i) ^ mask_i;
        fold_s   = 6'd0;
        for (int c = 0; c < CHUNKS; c++) begin
            fold_s = fold_s ^ padded_s[c*6 +: 6];
        end
        if (fold_s < 6'(DECK_SIZE)) begin
            idx_o = fold_s;
        end else begin
            idx_o = fold_s - 6'(DECK_SIZE);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Draws cards from a 52-card deck without repeats by linear probing a presence bitmap.
// Optional build macro CARD_DEALER_LFSR_EN mixes a free-running LFSR into the seed.
module card_dealer
    import card_dealer_pkg::*;
#(
    parameter int SEED_WIDTH = 12
) (
    input  logic                  clk_50M,
    input  logic                  i_Reset,
    input  logic [SEED_WIDTH-1:0] i_Seed,
    input  logic                  i_Draw,
    input  logic                  i_NewDeck,
    output logic                  o_Valid,
    output logic [3:0]            o_Rank,
    output logic [1:0]            o_Suit,
    output logic [4:0]            o_Points,
    output logic                  o_IsAce,
    output logic                  o_Busy,
    output logic                  o_Empty,
    output logic [5:0]            o_Remaining
);

    localparam int PAD_WIDTH = ((SEED_WIDTH + 5) / 6) * 6;

    state_e                 state_q, state_d;
    logic [DECK_SIZE-1:0]   deck_q, deck_d;
    logic [5:0]             idx_q, idx_d;
    logic [5:0]             remaining_q, remaining_d;
    logic                   empty_q, empty_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [3:0]             rank_q, rank_d;
    logic [1:0]             suit_q, suit_d;
    logic [4:0]             points_q, points_d;
    logic                   ace_q, ace_d;

    logic [PAD_WIDTH-1:0]   mask_s;
    logic [5:0]             red_idx_s;
    logic [5:0]             base_s;
    logic [3:0]             card_rank_s;
    logic [1:0]             card_suit_s;

`ifdef CARD_DEALER_LFSR_EN
    logic [11:0] lfsr_q, lfsr_d;

    // Galois LFSR next state
    always_comb begin
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
    end

    // LFSR advances every clock, independent of the FSM
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mask_s = PAD_WIDTH'(lfsr_q);
`else
    assign mask_s = '0;
`endif

    card_index_reduce #(
        .SEED_WIDTH (SEED_WIDTH),
        .PAD_WIDTH  (PAD_WIDTH)
    ) u_reduce (
        .seed_i (i_Seed),
        .mask_i (mask_s),
        .idx_o  (red_idx_s)
    );

    // Compare chain instead of a divider: idx -> suit and rank
    always_comb begin
        if (idx_q < 6'(RANKS)) begin
            card_suit_s = 2'd0;
            base_s      = 6'd0;
        end else if (idx_q < 6'(2 * RANKS)) begin
            card_suit_s = 2'd1;
            base_s      = 6'(RANKS);
        end else if (idx_q < 6'(3 * RANKS)) begin
            card_suit_s = 2'd2;
            base_s      = 6'(2 * RANKS);
        end else begin
            card_suit_s = 2'd3;
            base_s      = 6'(3 * RANKS);
        end
        card_rank_s = 4'(idx_q - base_s + 6'd1);
    end

    // FSM next state; a deck refill overrides any draw activity
    always_comb begin
        state_d     = state_q;
        deck_d      = deck_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        empty_d     = empty_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        rank_d      = rank_q;
        suit_d      = suit_q;
        points_d    = points_q;
        ace_d       = ace_q;

        if (i_NewDeck) begin
            state_d     = ST_IDLE;
            deck_d      = {DECK_SIZE{1'b1}};
            remaining_d = 6'(DECK_SIZE);
            empty_d     = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Draw && !empty_q) begin
                        idx_d   = red_idx_s;
                        busy_d  = 1'b1;
                        state_d = ST_PROBE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PROBE: begin
                    if (deck_q[idx_q]) begin
                        deck_d[idx_q] = 1'b0;
                        remaining_d   = remaining_q - 6'd1;
                        empty_d       = (remaining_q == 6'd1);
                        rank_d        = card_rank_s;
                        suit_d        = card_suit_s;
                        points_d      = points_of(card_rank_s);
                        ace_d         = (card_rank_s == 4'd1);
                        valid_d       = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = ST_IDLE;
                    end else if (idx_q == 6'(DECK_SIZE - 1)) begin
                        idx_d = 6'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            deck_q      <= {DECK_SIZE{1'b1}};
            idx_q       <= 6'd0;
            remaining_q <= 6'(DECK_SIZE);
            empty_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            rank_q      <= 4'd0;
            suit_q      <= 2'd0;
            points_q    <= 5'd0;
            ace_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            deck_q      <= deck_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            empty_q     <= empty_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            rank_q      <= rank_d;
            suit_q      <= suit_d;
            points_q    <= points_d;
            ace_q       <= ace_d;
        end
    end

    assign o_Valid     = valid_q;
    assign o_Rank      = rank_q;
    assign o_Suit      = suit_q;
    assign o_Points    = points_q;
    assign o_IsAce     = ace_q;
    assign o_Busy      = busy_q;
    assign o_Empty     = empty_q;
    assign o_Remaining = remaining_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: directed draws push expected cards, a monitor checks each o_Valid.
module tb_card_dealer;

    localparam int SW = 12;

    logic          clk_50M = 1'b0;
    logic          i_Reset;
    logic [SW-1:0] i_Seed;
    logic          i_Draw;
    logic          i_NewDeck;
    logic          o_Valid;
    logic [3:0]    o_Rank;
    logic [1:0]    o_Suit;
    logic [4:0]    o_Points;
    logic          o_IsAce;
    logic          o_Busy;
    logic          o_Empty;
    logic [5:0]    o_Remaining;

    always #10 clk_50M = ~clk_50M;

    card_dealer #(.SEED_WIDTH(SW)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Seed      (i_Seed),
        .i_Draw      (i_Draw),
        .i_NewDeck   (i_NewDeck),
        .o_Valid     (o_Valid),
        .o_Rank      (o_Rank),
        .o_Suit      (o_Suit),
        .o_Points    (o_Points),
        .o_IsAce     (o_IsAce),
        .o_Busy      (o_Busy),
        .o_Empty     (o_Empty),
        .o_Remaining (o_Remaining)
    );

    typedef struct {
        int rank;
        int suit;
        int points;
        int ace;
        int rem;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_fail    = 0;
    int   valid_cnt = 0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every o_Valid pulse must match the oldest expected card
    always @(negedge clk_50M) begin
        exp_t e;
        if (o_Valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rank", int'(o_Rank), e.rank);
                chk("suit", int'(o_Suit), e.suit);
                chk("points", int'(o_Points), e.points);
                chk("is_ace", int'(o_IsAce), e.ace);
                chk("remaining", int'(o_Remaining), e.rem);
                chk("empty", int'(o_Empty), (e.rem == 0) ? 1 : 0);
                chk("busy_at_valid", int'(o_Busy), 0);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_50M);
        i_Reset   = 1'b1;
        i_Draw    = 1'b0;
        i_NewDeck = 1'b0;
        i_Seed    = '0;
        repeat (2) @(negedge clk_50M);
        i_Reset = 1'b0;
        sb.delete();
    endtask

    // One draw; k is the number of occupied slots the probe must skip
    task automatic draw(input int seed, input int rank, input int suit, input int rem, input int k);
        exp_t e;
        @(negedge clk_50M);
        i_Seed   = SW'(seed);
        i_Draw   = 1'b1;
        e.rank   = rank;
        e.suit   = suit;
        e.points = (rank > 10) ? 10 : rank;
        e.ace    = (rank == 1) ? 1 : 0;
        e.rem    = rem;
        e.cyc    = cyc + 2 + k;
        sb.push_back(e);
        @(negedge clk_50M);
        i_Draw = 1'b0;
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk_50M);
        if (sb.size() != 0) begin
            chk("draw_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int v0;
        v0 = valid_cnt;
        repeat (cycles) @(negedge clk_50M);
        chk(name, valid_cnt - v0, 0);
    endtask

    task automatic new_deck();
        @(negedge clk_50M);
        i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
    endtask

    initial begin
        i_Reset   = 1'b1;
        i_Draw    = 1'b0;
        i_NewDeck = 1'b0;
        i_Seed    = '0;
        do_reset();

        chk("rst_valid", int'(o_Valid), 0);
        chk("rst_rank", int'(o_Rank), 0);
        chk("rst_suit", int'(o_Suit), 0);
        chk("rst_points", int'(o_Points), 0);
        chk("rst_ace", int'(o_IsAce), 0);
        chk("rst_busy", int'(o_Busy), 0);
        chk("rst_empty", int'(o_Empty), 0);
        chk("rst_remaining", int'(o_Remaining), 52);

        // Basic draws and probing past an occupied slot
        draw(0, 1, 0, 51, 0);
        draw(0, 2, 0, 50, 1);
        draw(55, 4, 0, 49, 0);
        draw(12'h0C0, 5, 0, 48, 1);

        // Wrap-around from the last slot
        do_reset();
        draw(51, 13, 3, 51, 0);
        draw(51, 1, 0, 50, 1);

        // Exhaust the deck in order
        do_reset();
        for (int i = 0; i < 52; i++) begin
            draw(0, (i % 13) + 1, i / 13, 51 - i, i);
        end
        chk("exhaust_empty", int'(o_Empty), 1);
        chk("exhaust_remaining", int'(o_Remaining), 0);
        @(negedge clk_50M);
        i_Draw = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0;
        chk("empty_draw_busy", int'(o_Busy), 0);
        expect_quiet("empty_draw_no_valid", 60);
        new_deck();
        chk("refill_remaining", int'(o_Remaining), 52);
        chk("refill_empty", int'(o_Empty), 0);
        chk("refill_rank_held", int'(o_Rank), 13);

        // Abort an in-progress draw with a refill
        for (int i = 0; i < 10; i++) begin
            draw(0, i + 1, 0, 51 - i, i);
        end
        @(negedge clk_50M);
        i_Seed = '0;
        i_Draw = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0;
        @(negedge clk_50M);
        chk("abort_busy_before", int'(o_Busy), 1);
        @(negedge clk_50M);
        i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
        chk("abort_busy_after", int'(o_Busy), 0);
        chk("abort_remaining", int'(o_Remaining), 52);
        chk("abort_rank_held", int'(o_Rank), 10);
        expect_quiet("abort_no_valid", 20);

        // Same-cycle draw and refill: refill wins
        @(negedge clk_50M);
        i_Draw    = 1'b1;
        i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_Draw    = 1'b0;
        i_NewDeck = 1'b0;
        chk("collide_busy", int'(o_Busy), 0);
        expect_quiet("collide_no_valid", 10);
        chk("collide_remaining", int'(o_Remaining), 52);

        // Deck still intact after the dropped draw
        draw(0, 1, 0, 51, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
